fifo_sequencer: RTL and testbench
=================================

# fifo_sequencer

Clocked sequencer for the FT245-style USB FIFO behind the PIA keyboard (port A) and display (port B) paths. It arbitrates between pending host-to-Apple reads and Apple-to-host writes. It generates correctly timed RD#/WR strobes and buffers one byte in each direction. It replaces purely combinational strobe generation, so FIFO timing holds regardless of CPU access pattern.

## Interface
- RD_PULSE, 4: cycles fifo_rd_n is held low per read (1..15)
- WR_PULSE, 3: cycles fifo_wr is held high per write (1..15)
- RECOVERY, 3: idle cycles after any access before the next (1..15)

- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  permits new FIFO accesses
- rx_ready  out  1  rx buffer holds a byte (drives PIA CA1)
- rx_data  out  7  rx buffer contents
- rx_ack  in  1  consumer took rx byte (PIA CA2 read strobe)
- tx_ready  out  1  tx buffer empty, may accept byte (drives PIA CB1)
- tx_req  in  1  producer offers tx_data (PIA CB2 write strobe)
- tx_data  in  7  byte to send (PIA PB)
- fifo_rxf_n  in  1  FIFO has data, active low
- fifo_txe_n  in  1  FIFO has space, active low
- fifo_rd_n  out  1  FIFO read strobe, active low
- fifo_wr  out  1  FIFO write strobe, active high
- fifo_data  inout  7  FIFO data bus

## Operation
- States: IDLE, RD_ACTIVE, WR_SETUP, WR_ACTIVE, WR_HOLD, RECOVER. A 4-bit down-counter times RD_ACTIVE, WR_ACTIVE and RECOVER.
- Read eligible: enable && rxf low (as sampled) && !rx_ready.
- Write eligible: enable && tx_pending && txe low (as sampled).
- IDLE arbitration: if only one is eligible, take it. If both are eligible, take the opposite of the last-served direction. After reset, last-served = write, so the first contention goes to read.
- RD_ACTIVE: fifo_rd_n=0 for RD_PULSE cycles. On the edge that ends the pulse: capture fifo_data into rx_data, set rx_ready, raise fifo_rd_n, enter RECOVER.
- WR_SETUP (1 cycle): drive tx buffer onto fifo_data, fifo_wr=0.
- WR_ACTIVE: fifo_wr=1 for WR_PULSE cycles while data stays driven.
- WR_HOLD (1 cycle): fifo_wr=0, data still driven. Clear tx_pending, enter RECOVER.
- fifo_data is driven only in WR_SETUP, WR_ACTIVE and WR_HOLD; it is high-Z otherwise.
- RECOVER: RECOVERY cycles, then IDLE. No strobe is active.
- rx_ack sampled high while rx_ready=1: clear rx_ready on that edge. rx_ack while rx_ready=0: ignored.
- tx_req sampled high while tx_ready=1: latch tx_data, set tx_pending, drop tx_ready. tx_req while tx_ready=0: ignored; the byte is dropped.
- tx_ready = !tx_pending.
- Deasserting enable mid-access never truncates a strobe. The current access and its RECOVER complete; no new access starts.
- Reset values: fifo_rd_n=1, fifo_wr=0, fifo_data=Z, rx_ready=0, rx_data=0, tx_ready=1, state=IDLE. Asynchronous reset mid-access forces these values immediately.

## Timing
- All outputs are registered except the fifo_data tri-state, which is decoded from registered state.
- Read latency, macro off: rxf_n low before edge k, so fifo_rd_n falls after edge k and rx_ready rises after edge k+RD_PULSE.
- Read latency, macro on: add 2 cycles.
- Write latency: tx_req at edge k sets tx_pending. If txe_n is already low and the FSM is idle, WR_SETUP starts at edge k+1 (k+3 with the macro).
- Access period: read is RD_PULSE+RECOVERY cycles; write is WR_PULSE+2+RECOVERY cycles.
- RECOVERY must be at least the status-sampling depth (1, or 3 with the macro) so a stale rxf/txe is never acted on.

## Configuration
- FIFO_SYNC_EN defined: fifo_rxf_n and fifo_txe_n pass through 2-flop synchronizers before arbitration. This adds 2 cycles of status latency.
- FIFO_SYNC_EN undefined: the status pins are sampled directly by the IDLE decision logic. This is valid only when the FIFO status is synchronous to clk.

## Test plan
- Read, macro off, RD_PULSE=4: rxf_n low with fifo_data=7'h41 -> fifo_rd_n low exactly 4 cycles; rx_data=7'h41 and rx_ready=1 on the rising edge; no second read until rx_ack.
- Write: tx_req with tx_data=7'h0D, txe_n low -> tx_ready=0; 1 setup cycle, fifo_wr high 3 cycles with fifo_data=7'h0D held through the hold cycle, then Z; tx_ready=1 after WR_HOLD.
- Contention: rxf_n low, tx pending and txe_n low from reset -> order is read, write, read (alternating) with RECOVERY=3 idle cycles between each.
- Backpressure: txe_n high with a byte pending -> no fifo_wr and a second tx_req is ignored; txe_n low -> the original byte is written.
- enable dropped 1 cycle into a read -> fifo_rd_n stays low the full 4 cycles, the byte is captured, no further access while enable=0.
- reset_n asserted during WR_ACTIVE -> fifo_wr=0, fifo_data=Z and tx_ready=1 without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_sequencer.sv
// FT245-style USB FIFO strobe sequencer with one-byte rx/tx buffers toward the PIA ports.
// Define FIFO_SYNC_EN to pass fifo_rxf_n/fifo_txe_n through 2-flop synchronizers.
module fifo_sequencer #(
    parameter int RD_PULSE = 4,
    parameter int WR_PULSE = 3,
    parameter int RECOVERY = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable_i,
    output logic       rx_ready_o,
    output logic [6:0] rx_data_o,
    input  logic       rx_ack_i,
    output logic       tx_ready_o,
    input  logic       tx_req_i,
    input  logic [6:0] tx_data_i,
    input  logic       fifo_rxf_n_i,
    input  logic       fifo_txe_n_i,
    output logic       fifo_rd_n_o,
    output logic       fifo_wr_o,
    inout  wire  [6:0] fifo_data_io
);

    typedef enum logic [2:0] {
        IDLE, RD_ACTIVE, WR_SETUP, WR_ACTIVE, WR_HOLD, RECOVER
    } state_e;

    localparam logic [3:0] RD_LOAD  = 4'(RD_PULSE - 1);
    localparam logic [3:0] WR_LOAD  = 4'(WR_PULSE - 1);
    // The IDLE arbitration cycle is the last recovery cycle, so RECOVER itself lasts RECOVERY-1.
    localparam logic [3:0] REC_LOAD = 4'(RECOVERY - 2);
    localparam state_e     AFTER_ACCESS = (RECOVERY > 1) ? RECOVER : IDLE;

    state_e     state_q;
    logic [3:0] cnt_q;
    logic       rx_ready_q;
    logic       tx_ready_q;
    logic       fifo_rd_n_q;
    logic       fifo_wr_q;
    logic       last_wr_q;
    logic [6:0] rx_data_q;
    logic [6:0] tx_data_q;

    logic rxf_n_s;
    logic txe_n_s;
    logic rd_elig;
    logic wr_elig;
    logic data_oe;

`ifdef FIFO_SYNC_EN
    logic [1:0] rxf_sync_q;
    logic [1:0] txe_sync_q;

    // Synchronizers reset to the inactive (high) level so nothing is acted on out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxf_sync_q <= 2'b11;
            txe_sync_q <= 2'b11;
        end else begin
            rxf_sync_q <= {rxf_sync_q[0], fifo_rxf_n_i};
            txe_sync_q <= {txe_sync_q[0], fifo_txe_n_i};
        end
    end

    assign rxf_n_s = rxf_sync_q[1];
    assign txe_n_s = txe_sync_q[1];
`else
    assign rxf_n_s = fifo_rxf_n_i;
    assign txe_n_s = fifo_txe_n_i;
`endif

    assign rd_elig = enable_i && !rxf_n_s && !rx_ready_q;
    assign wr_elig = enable_i && !tx_ready_q && !txe_n_s;
    assign data_oe = (state_q == WR_SETUP) || (state_q == WR_ACTIVE) || (state_q == WR_HOLD);

    // NOTE: every register below uses <= so all branches see pre-edge values; the later
    // assignment in the case statement wins when a buffer flag is both cleared and set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rx_ready_q  <= 1'b0;
            rx_data_q   <= '0;
            tx_ready_q  <= 1'b1;
            tx_data_q   <= '0;
            fifo_rd_n_q <= 1'b1;
            fifo_wr_q   <= 1'b0;
            last_wr_q   <= 1'b1;
        end else begin
            if (rx_ack_i && rx_ready_q) rx_ready_q <= 1'b0;
            if (tx_req_i && tx_ready_q) begin
                tx_data_q  <= tx_data_i;
                tx_ready_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (rd_elig && (!wr_elig || last_wr_q)) begin
                        state_q     <= RD_ACTIVE;
                        cnt_q       <= RD_LOAD;
                        fifo_rd_n_q <= 1'b0;
                        last_wr_q   <= 1'b0;
                    end else if (wr_elig) begin
                        state_q   <= WR_SETUP;
                        last_wr_q <= 1'b1;
                    end
                end
                RD_ACTIVE: begin
                    if (cnt_q == 4'd0) begin
                        rx_data_q   <= fifo_data_io;
                        rx_ready_q  <= 1'b1;
                        fifo_rd_n_q <= 1'b1;
                        state_q     <= AFTER_ACCESS;
                        cnt_q       <= REC_LOAD;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                WR_SETUP: begin
                    state_q   <= WR_ACTIVE;
                    cnt_q     <= WR_LOAD;
                    fifo_wr_q <= 1'b1;
                end
                WR_ACTIVE: begin
                    if (cnt_q == 4'd0) begin
                        state_q   <= WR_HOLD;
                        fifo_wr_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                WR_HOLD: begin
                    tx_ready_q <= 1'b1;
                    state_q    <= AFTER_ACCESS;
                    cnt_q      <= REC_LOAD;
                end
                RECOVER: begin
                    if (cnt_q == 4'd0) state_q <= IDLE;
                    else               cnt_q   <= cnt_q - 4'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fifo_data_io = data_oe ? tx_data_q : 7'bz;
    assign rx_ready_o   = rx_ready_q;
    assign rx_data_o    = rx_data_q;
    assign tx_ready_o   = tx_ready_q;
    assign fifo_rd_n_o  = fifo_rd_n_q;
    assign fifo_wr_o    = fifo_wr_q;

endmodule

// File: tb/tb_fifo_sequencer.sv
// Self-checking bench for fifo_sequencer: vector table, directed corner sequences and a
// randomized run against a schedule-based reference model.
module tb_fifo_sequencer;

    localparam int         RD_PULSE = 4;
    localparam int         WR_PULSE = 3;
    localparam int         RECOVERY = 3;
    localparam logic [6:0] BUS_IDLE = 7'h7F;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       rx_ack = 1'b0;
    logic       tx_req = 1'b0;
    logic       fifo_rxf_n = 1'b1;
    logic       fifo_txe_n = 1'b1;
    logic [6:0] tx_data = '0;
    logic [6:0] fbyte = '0;
    logic       rx_ready;
    logic       tx_ready;
    logic       fifo_rd_n;
    logic       fifo_wr;
    logic [6:0] rx_data;
    tri1  [6:0] fifo_data;

    // FIFO device model: drives its byte while RD# is low; the bus floats high otherwise.
    assign fifo_data = !fifo_rd_n ? fbyte : 7'bz;

    fifo_sequencer #(
        .RD_PULSE(RD_PULSE), .WR_PULSE(WR_PULSE), .RECOVERY(RECOVERY)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable_i(enable),
        .rx_ready_o(rx_ready), .rx_data_o(rx_data), .rx_ack_i(rx_ack),
        .tx_ready_o(tx_ready), .tx_req_i(tx_req), .tx_data_i(tx_data),
        .fifo_rxf_n_i(fifo_rxf_n), .fifo_txe_n_i(fifo_txe_n),
        .fifo_rd_n_o(fifo_rd_n), .fifo_wr_o(fifo_wr), .fifo_data_io(fifo_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; enable = 1'b0; rx_ack = 1'b0; tx_req = 1'b0;
        fifo_rxf_n = 1'b1; fifo_txe_n = 1'b1; tx_data = '0; fbyte = '0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    typedef struct packed {
        logic       en, rxf_n, txe_n, ack, req;
        logic [6:0] txd, fb;
        logic       e_rd_n, e_wr, e_rdy;
        logic [6:0] e_rxd;
        logic       e_txr;
        logic [6:0] e_bus;
    } vec_t;

    vec_t vt[24];

    function automatic vec_t mk(input logic en, rxf_n, txe_n, ack, req, input logic [6:0] txd, fb,
                                input logic rd_n, wr, rdy, input logic [6:0] rxd,
                                input logic txr, input logic [6:0] bus);
        return '{en, rxf_n, txe_n, ack, req, txd, fb, rd_n, wr, rdy, rxd, txr, bus};
    endfunction

    // Reference model: accesses are a schedule of (kind, start edge) with the next free edge
    // computed from pulse widths; buffer flags follow the handshake rules directly.
    int         m_free, m_kind, m_start;
    bit         m_rdy, m_pend, m_last_wr;
    logic [6:0] m_rxd, m_txb, m_e_bus;
    logic       m_e_rd_n, m_e_wr;

    function automatic void model_init();
        m_free = 0; m_kind = 0; m_start = 0;
        m_rdy = 1'b0; m_pend = 1'b0; m_last_wr = 1'b1;
        m_rxd = '0; m_txb = '0;
    endfunction

    function automatic void model_edge(input int c);
        bit rdy_pre, pend_pre, rd_e, wr_e;
        rdy_pre  = m_rdy;
        pend_pre = m_pend;
        if (m_kind == 1 && c == m_start + RD_PULSE) begin m_rdy = 1'b1; m_rxd = fbyte; end
        if (m_kind == 2 && c == m_start + WR_PULSE + 2) m_pend = 1'b0;
        if (rx_ack && rdy_pre) m_rdy = 1'b0;
        if (tx_req && !pend_pre) begin m_pend = 1'b1; m_txb = tx_data; end
        if (c >= m_free) begin
            rd_e = enable && !fifo_rxf_n && !rdy_pre;
            wr_e = enable && pend_pre && !fifo_txe_n;
            if (rd_e && (!wr_e || m_last_wr)) begin
                m_kind = 1; m_start = c; m_free = c + RD_PULSE + RECOVERY; m_last_wr = 1'b0;
            end else if (wr_e) begin
                m_kind = 2; m_start = c; m_free = c + WR_PULSE + 2 + RECOVERY; m_last_wr = 1'b1;
            end
        end
        m_e_rd_n = !(m_kind == 1 && c >= m_start && c < m_start + RD_PULSE);
        m_e_wr   = (m_kind == 2 && c > m_start && c <= m_start + WR_PULSE);
        if (m_kind == 2 && c >= m_start && c <= m_start + WR_PULSE + 1) m_e_bus = m_txb;
        else if (!m_e_rd_n)                                           m_e_bus = fbyte;
        else                                                          m_e_bus = BUS_IDLE;
    endfunction

    int         ev_t[4];
    bit         ev_w[4];
    int         nev, lows, wr_hi, found;
    logic       prev_rd_n, prev_wr, got_rdy;
    logic [6:0] cap;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while reset is held.
        reset_n = 1'b0;
        step();
        step();
        check("rst_rd_n", fifo_rd_n, 1);
        check("rst_wr", fifo_wr, 0);
        check("rst_rx_ready", rx_ready, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_bus", fifo_data, BUS_IDLE);
        reset_n = 1'b1;

        // Read 0x41, blocked second read, ack, read 0x52, then a write of 0x0D with an
        // ignored offer of 0x55 mid-write.
        for (int i = 0; i < 4; i++) vt[i] = mk(1,0,1,0,0,7'h00,7'h41, 0,0,0,7'h00,1,7'h41);
        for (int i = 4; i < 9; i++) vt[i] = mk(1,0,1,0,0,7'h00,7'h41, 1,0,1,7'h41,1,BUS_IDLE);
        vt[9]  = mk(1,0,1,1,0,7'h00,7'h41, 1,0,0,7'h41,1,BUS_IDLE);
        vt[10] = mk(1,0,1,0,0,7'h00,7'h52, 0,0,0,7'h41,1,7'h52);
        for (int i = 11; i < 14; i++) vt[i] = mk(1,1,1,0,0,7'h00,7'h52, 0,0,0,7'h41,1,7'h52);
        vt[14] = mk(1,1,1,0,0,7'h00,7'h52, 1,0,1,7'h52,1,BUS_IDLE);
        vt[15] = mk(1,1,1,1,0,7'h00,7'h52, 1,0,0,7'h52,1,BUS_IDLE);
        vt[16] = mk(1,1,0,0,1,7'h0D,7'h52, 1,0,0,7'h52,0,BUS_IDLE);
        vt[17] = mk(1,1,0,0,0,7'h00,7'h52, 1,0,0,7'h52,0,7'h0D);
        vt[18] = mk(1,1,0,0,1,7'h55,7'h52, 1,1,0,7'h52,0,7'h0D);
        vt[19] = mk(1,1,0,0,0,7'h00,7'h52, 1,1,0,7'h52,0,7'h0D);
        vt[20] = mk(1,1,0,0,0,7'h00,7'h52, 1,1,0,7'h52,0,7'h0D);
        vt[21] = mk(1,1,0,0,0,7'h00,7'h52, 1,0,0,7'h52,0,7'h0D);
        vt[22] = mk(1,1,0,0,0,7'h00,7'h52, 1,0,0,7'h52,1,BUS_IDLE);
        vt[23] = mk(1,1,0,0,0,7'h00,7'h52, 1,0,0,7'h52,1,BUS_IDLE);

        for (int i = 0; i < 24; i++) begin
            enable = vt[i].en; fifo_rxf_n = vt[i].rxf_n; fifo_txe_n = vt[i].txe_n;
            rx_ack = vt[i].ack; tx_req = vt[i].req; tx_data = vt[i].txd; fbyte = vt[i].fb;
            step();
            check($sformatf("vec%0d_rd_n", i), fifo_rd_n, vt[i].e_rd_n);
            check($sformatf("vec%0d_wr", i), fifo_wr, vt[i].e_wr);
            check($sformatf("vec%0d_rx_ready", i), rx_ready, vt[i].e_rdy);
            check($sformatf("vec%0d_rx_data", i), rx_data, vt[i].e_rxd);
            check($sformatf("vec%0d_tx_ready", i), tx_ready, vt[i].e_txr);
            check($sformatf("vec%0d_bus", i), fifo_data, vt[i].e_bus);
        end

        // Contention from reset: read, write, read, write with recovery gaps between.
        do_reset();
        tx_req = 1'b1; tx_data = 7'h0D; fifo_rxf_n = 1'b0; fifo_txe_n = 1'b0; fbyte = 7'h11;
        step();
        tx_req = 1'b0; enable = 1'b1;
        nev = 0; prev_rd_n = 1'b1; prev_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin ev_t[i] = -100; ev_w[i] = 1'b0; end
        for (int t = 0; t < 120 && nev < 4; t++) begin
            step();
            if (prev_rd_n && !fifo_rd_n) begin ev_t[nev] = t; ev_w[nev] = 1'b0; nev++; end
            else if (!prev_wr && fifo_wr) begin ev_t[nev] = t; ev_w[nev] = 1'b1; nev++; end
            prev_rd_n = fifo_rd_n; prev_wr = fifo_wr;
            rx_ack = rx_ready; tx_req = tx_ready; tx_data = 7'h0D;
        end
        rx_ack = 1'b0; tx_req = 1'b0;
        check("cont_events", nev, 4);
        check("cont_kind0", ev_w[0], 0);
        check("cont_kind1", ev_w[1], 1);
        check("cont_kind2", ev_w[2], 0);
        check("cont_kind3", ev_w[3], 1);
        check("cont_gap_rw", ev_t[1] - ev_t[0], RD_PULSE + RECOVERY + 1);
        check("cont_gap_wr", ev_t[2] - ev_t[1], WR_PULSE + 1 + RECOVERY);
        check("cont_gap_rw2", ev_t[3] - ev_t[2], RD_PULSE + RECOVERY + 1);

        // enable dropped one cycle into a read.
        do_reset();
        enable = 1'b1; fifo_rxf_n = 1'b0; fbyte = 7'h33;
        lows = 0; got_rdy = 1'b0; cap = '0;
        for (int t = 0; t < 25; t++) begin
            step();
            if (t == 0) enable = 1'b0;
            if (!fifo_rd_n) lows++;
            if (rx_ready && !got_rdy) begin got_rdy = 1'b1; cap = rx_data; end
            rx_ack = rx_ready;
        end
        rx_ack = 1'b0;
        check("endrop_rd_low_cycles", lows, RD_PULSE);
        check("endrop_captured", got_rdy, 1);
        check("endrop_rx_data", cap, 7'h33);

        // Backpressure: pending byte waits for txe_n, a second offer is dropped.
        do_reset();
        enable = 1'b1; tx_req = 1'b1; tx_data = 7'h0D;
        step();
        tx_req = 1'b0;
        check("bp_tx_ready_low", tx_ready, 0);
        wr_hi = 0;
        for (int t = 0; t < 10; t++) begin
            tx_req = (t == 3); tx_data = (t == 3) ? 7'h2A : 7'h00;
            step();
            if (fifo_wr) wr_hi++;
        end
        tx_req = 1'b0;
        check("bp_no_wr", wr_hi, 0);
        check("bp_still_pending", tx_ready, 0);
        fifo_txe_n = 1'b0;
        found = 0; cap = '0;
        for (int t = 0; t < 10 && found == 0; t++) begin
            step();
            if (fifo_data != BUS_IDLE) begin found = 1; cap = fifo_data; end
        end
        check("bp_write_started", found, 1);
        check("bp_write_byte", cap, 7'h0D);
        found = 0;
        for (int t = 0; t < 20 && found == 0; t++) begin
            step();
            if (tx_ready) found = 1;
        end
        check("bp_tx_ready_back", found, 1);
        wr_hi = 0;
        for (int t = 0; t < 15; t++) begin
            step();
            if (fifo_wr) wr_hi++;
        end
        check("bp_dropped_not_written", wr_hi, 0);

        // Asynchronous reset during WR_ACTIVE.
        do_reset();
        enable = 1'b1; fifo_txe_n = 1'b0; tx_req = 1'b1; tx_data = 7'h0D;
        step();
        tx_req = 1'b0;
        found = 0;
        for (int t = 0; t < 10 && found == 0; t++) begin
            step();
            if (fifo_wr) found = 1;
        end
        check("arst_reached_wr", found, 1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_wr", fifo_wr, 0);
        check("arst_bus", fifo_data, BUS_IDLE);
        check("arst_tx_ready", tx_ready, 1);
        check("arst_rd_n", fifo_rd_n, 1);
        @(negedge clk);

        // Randomized traffic against the reference model.
        do_reset();
        model_init();
        for (int c = 0; c < 1500; c++) begin
            enable     = ($urandom_range(9) != 0);
            fifo_rxf_n = ($urandom_range(4) >= 2);
            fifo_txe_n = ($urandom_range(1) == 1);
            rx_ack     = ($urandom_range(9) < 3);
            tx_req     = ($urandom_range(9) < 3);
            tx_data    = 7'($urandom);
            fbyte      = 7'($urandom);
            model_edge(c);
            step();
            check($sformatf("rnd%0d_rd_n", c), fifo_rd_n, m_e_rd_n);
            check($sformatf("rnd%0d_wr", c), fifo_wr, m_e_wr);
            check($sformatf("rnd%0d_rx_ready", c), rx_ready, m_rdy);
            check($sformatf("rnd%0d_rx_data", c), rx_data, m_rxd);
            check($sformatf("rnd%0d_tx_ready", c), tx_ready, !m_pend);
            check($sformatf("rnd%0d_bus", c), fifo_data, m_e_bus);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
